// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_pkg
// Description : Shared definitions for the instruction-fetch front end:
//               bus widths, default reset vector and the fetch FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

  // Bus widths
  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  // Default fetch address after reset (MIPS-style boot vector)
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Fetch FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // issuing sequential requests at pc
    ST_DROP  = 2'd1,  // waiting out a stale request after a redirect
    ST_HALT  = 2'd2   // parked after a misaligned redirect target
  } fetch_state_e;

endpackage : pc_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program-counter and instruction-fetch controller. Issues
//               sequential word fetches, holds one fetched word in an output
//               slot for decode, and handles branch/exception redirects
//               including redirects that arrive while a request is in flight.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active low
//   stall          in   1   decode cannot accept the slot this cycle
//   branch_valid   in   1   branch redirect request
//   branch_target  in   32  branch redirect address
//   exc_valid      in   1   exception/eret redirect request (has priority)
//   exc_target     in   32  exception redirect address
//   imem_req       out  1   instruction memory request
//   imem_addr      out  32  request address
//   imem_ack       in   1   request completed, imem_rdata valid
//   imem_rdata     in   32  fetched word
//   if_valid       out  1   slot holds a word for decode
//   if_pc          out  32  address of the slot word
//   if_inst        out  32  slot word
//   if_adel        out  1   slot reports an address-error (misaligned fetch)
// ============================================================================
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              exc_valid,
  input  logic [XLEN-1:0]   exc_target,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_adel
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic               if_valid_q, if_valid_d;
  logic               if_adel_q, if_adel_d;
  logic [XLEN-1:0]    if_pc_q, if_pc_d;
  logic [INST_W-1:0]  if_inst_q, if_inst_d;

  logic               w_redirect;
  logic [XLEN-1:0]    w_target;
  logic               w_accept;
  logic               w_consume;

  assign w_redirect = exc_valid | branch_valid;
  assign w_target   = exc_valid ? exc_target : branch_target;
  assign w_accept   = imem_req & imem_ack;
  assign w_consume  = if_valid_q & ~stall;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      if_valid_q <= 1'b0;
      if_adel_q  <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_adel_q  <= if_adel_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and slot logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_adel_d  = if_adel_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (w_consume) begin
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
    end

    if (w_redirect) begin
      // Decode only redirects after taking any delay-slot word, so the slot
      // is always flushed here, stall or not.
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
      if (w_target[1:0] != 2'b00) begin
        // Misaligned target: report it through the slot, never fetch it.
        if_valid_d = 1'b1;
        if_adel_d  = 1'b1;
        if_pc_d    = w_target;
        if_inst_d  = '0;
        state_d    = ST_HALT;
      end else if (!imem_req || imem_ack) begin
        // Nothing left in flight (or it completes now and is dropped).
        pc_d    = w_target;
        state_d = ST_FETCH;
      end else begin
        // Request still outstanding: let it finish, then go to the target.
        // In DROP this simply overwrites the earlier pending target.
        pend_pc_d = w_target;
        state_d   = ST_DROP;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // imem_req is already gated off when the slot cannot take a word.
          if (w_accept) begin
            if_valid_d = 1'b1;
            if_adel_d  = 1'b0;
            if_pc_d    = pc_q;
            if_inst_d  = imem_rdata;
            pc_d       = pc_q + 32'd4;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            pc_d    = pend_pc_q;
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          // Parked until the next redirect.
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      ST_FETCH: imem_req = ~(if_valid_q & stall);
      ST_DROP:  imem_req = 1'b1;
      ST_HALT:  imem_req = 1'b0;
      default:  imem_req = 1'b0;
    endcase
    // No request may be presented while reset is held.
    if (!rst) begin
      imem_req = 1'b0;
    end
  end

  // In DROP pc still holds the stale address, keeping it stable until ack.
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_adel   = if_adel_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Directed self-checking bench for pc_fetch_ctrl.
// Revision    : 1.1 - checking task
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .exc_valid     (exc_valid),
        .exc_target    (exc_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_adel       (if_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        exc_valid     = 1'b0;
        exc_target    = 32'h0;
        imem_ack      = 1'b1;

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_req",     imem_req, 1'b0);
        check("rst_valid",   if_valid, 1'b0);
        check("rst_adel",    if_adel,  1'b0);
        check("rst_pc",      if_pc,    32'h0);
        check("rst_inst",    if_inst,  32'h0);

        // ---------------- sequential fetch ----------------
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("seq0_req",    imem_req,  1'b1);
        check("seq0_addr",   imem_addr, 32'hBFC0_0000);
        check("seq0_valid",  if_valid,  1'b0);
        tick();
        check("seq1_addr",   imem_addr, 32'hBFC0_0004);
        check("seq1_valid",  if_valid,  1'b1);
        check("seq1_ifpc",   if_pc,     32'hBFC0_0000);
        check("seq1_inst",   if_inst,   32'hE59A_5A5A);
        tick();
        check("seq2_addr",   imem_addr, 32'hBFC0_0008);
        check("seq2_ifpc",   if_pc,     32'hBFC0_0004);
        check("seq2_inst",   if_inst,   32'hE59A_5A5E);

        // ---------------- stall for 3 cycles ----------------
        stall = 1'b1;
        #1;
        check("stall_req0",  imem_req,  1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ifpc",  if_pc,     32'hBFC0_0004);
            check("stall_valid", if_valid,  1'b1);
            check("stall_req",   imem_req,  1'b0);
            check("stall_addr",  imem_addr, 32'hBFC0_0008);
        end
        stall = 1'b0;
        #1;
        check("unstall_req",  imem_req,  1'b1);
        tick();
        check("unstall_ifpc", if_pc,     32'hBFC0_0008);
        check("unstall_addr", imem_addr, 32'hBFC0_000C);

        // ---------------- branch with delayed ack (DROP) ----------------
        imem_ack      = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 32'h8000_1000;
        tick();
        branch_valid  = 1'b0;
        check("drop1_valid", if_valid,  1'b0);
        check("drop1_req",   imem_req,  1'b1);
        check("drop1_addr",  imem_addr, 32'hBFC0_000C);
        tick();
        check("drop2_addr",  imem_addr, 32'hBFC0_000C);
        check("drop2_valid", if_valid,  1'b0);
        imem_ack = 1'b1;
        tick();
        check("drop3_valid", if_valid,  1'b0);
        check("drop3_addr",  imem_addr, 32'h8000_1000);
        tick();
        check("br_ifpc",     if_pc,     32'h8000_1000);
        check("br_valid",    if_valid,  1'b1);
        check("br_addr",     imem_addr, 32'h8000_1004);

        // ---------------- exception wins over branch ----------------
        exc_valid     = 1'b1;
        exc_target    = 32'h8000_0180;
        branch_valid  = 1'b1;
        branch_target = 32'h8000_2000;
        tick();
        exc_valid    = 1'b0;
        branch_valid = 1'b0;
        check("exc_valid",   if_valid,  1'b0);
        check("exc_addr",    imem_addr, 32'h8000_0180);
        tick();
        check("exc_ifpc",    if_pc,     32'h8000_0180);
        check("exc_inst",    if_inst,   32'hDA5A_5BDA);

        // ---------------- misaligned branch -> HALT ----------------
        branch_valid  = 1'b1;
        branch_target = 32'h8000_1002;
        tick();
        branch_valid = 1'b0;
        check("adel_valid",  if_valid,  1'b1);
        check("adel_flag",   if_adel,   1'b1);
        check("adel_ifpc",   if_pc,     32'h8000_1002);
        check("adel_inst",   if_inst,   32'h0);
        check("adel_req",    imem_req,  1'b0);
        stall = 1'b1;
        tick();
        check("halt_hold_valid", if_valid, 1'b1);
        check("halt_hold_req",   imem_req, 1'b0);
        stall = 1'b0;
        tick();
        check("halt_cons_valid", if_valid, 1'b0);
        check("halt_cons_req",   imem_req, 1'b0);
        tick();
        check("halt_idle_req",   imem_req, 1'b0);
        branch_valid  = 1'b1;
        branch_target = 32'h8000_3000;
        tick();
        branch_valid = 1'b0;
        check("halt_exit_req",   imem_req,  1'b1);
        check("halt_exit_addr",  imem_addr, 32'h8000_3000);
        tick();
        check("halt_exit_ifpc",  if_pc,     32'h8000_3000);

        // ---------------- reset during DROP ----------------
        imem_ack      = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 32'h8000_4000;
        tick();
        branch_valid = 1'b0;
        check("rdrop_addr",  imem_addr, 32'h8000_3004);
        check("rdrop_req",   imem_req,  1'b1);
        #1 rst = 1'b0;
        #1;
        check("rdrop_rst_req",   imem_req, 1'b0);
        check("rdrop_rst_valid", if_valid, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("rdrop_rel_addr",  imem_addr, 32'hBFC0_0000);
        check("rdrop_rel_req",   imem_req,  1'b1);
        check("rdrop_rel_valid", if_valid,  1'b0);
        tick();
        check("rdrop_ifpc",      if_pc,     32'hBFC0_0000);
        check("rdrop_valid",     if_valid,  1'b1);

        // ---------------- pc wraps modulo 2^32 ----------------
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_valid = 1'b0;
        check("wrap0_addr",  imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap1_ifpc",  if_pc,     32'hFFFF_FFFC);
        check("wrap1_addr",  imem_addr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
`default_nettype wire
